// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl
// ---------------------------------------------------------------------------
// Exhaustively exercises one combinational gate under test (GUT). On start
// it drives every input vector in ascending order. It holds each vector for
// SETTLE cycles, then compares the GUT output with the truth-table value for
// the latched gate type. It reports pass/fail, the mismatch count and the
// first failing vector.
//
// Handshake: start is a level sampled only in IDLE. No ready is returned.
// busy high means the request was taken and a sweep is in flight. done is a
// one-cycle pulse that marks the final results as stable.
//
// Ports:
//   clk            in   rising-edge clock
//   rst            in   synchronous active-high reset
//   start          in   begin a sweep (IDLE only)
//   op_sel         in   gate type: 0 NOT,1 AND,2 OR,3 NAND,4 NOR,5 XOR,6 XNOR,7 BUF
//   dut_z          in   GUT output
//   vec_out        out  vector driven to the GUT inputs
//   busy           out  high whenever not IDLE
//   done           out  one-cycle completion pulse
//   pass           out  last sweep had zero mismatches
//   err_cnt        out  mismatch count of current/last sweep
//   fail_valid     out  at least one mismatch captured
//   first_fail_vec out  vector of the first mismatch
// ---------------------------------------------------------------------------
module gate_sweep_ctrl #(
  parameter int N_IN   = 2,
  parameter int SETTLE = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op_sel,
  input  logic              dut_z,
  output logic [N_IN-1:0]   vec_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     err_cnt,
  output logic              fail_valid,
  output logic [N_IN-1:0]   first_fail_vec
);

  localparam int CW = $clog2(SETTLE) + 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state;
  logic [2:0]    op_q;
  logic [CW-1:0] cnt;

  // Truth-table value for the vector currently on the GUT inputs.
  logic expected;
  always_comb begin
    expected = 1'b0;
    case (op_q)
      3'd0:    expected = ~vec_out[0];
      3'd1:    expected = &vec_out;
      3'd2:    expected = |vec_out;
      3'd3:    expected = ~&vec_out;
      3'd4:    expected = ~|vec_out;
      3'd5:    expected = ^vec_out;
      3'd6:    expected = ~^vec_out;
      default: expected = vec_out[0];
    endcase
  end

  logic          mismatch;
  logic [N_IN:0] err_next;
  assign mismatch = (dut_z != expected);
  assign err_next = err_cnt + {{N_IN{1'b0}}, mismatch};

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      op_q           <= 3'd0;
      cnt            <= '0;
      vec_out        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_cnt        <= '0;
      fail_valid     <= 1'b0;
      first_fail_vec <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            op_q           <= op_sel;
            vec_out        <= '0;
            err_cnt        <= '0;
            fail_valid     <= 1'b0;
            first_fail_vec <= '0;
            pass           <= 1'b0;
            cnt            <= CNT_LOAD;
            busy           <= 1'b1;
            state          <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          err_cnt <= err_next;
          if (mismatch && !fail_valid) begin
            first_fail_vec <= vec_out;
            fail_valid     <= 1'b1;
          end
          if (vec_out == {N_IN{1'b1}}) begin
            // Results are registered on entry to DONE so that they are
            // already final while the done pulse is high.
            done  <= 1'b1;
            pass  <= (err_next == '0);
            state <= S_DONE;
          end else begin
            vec_out <= vec_out + 1'b1;
            cnt     <= CNT_LOAD;
            state   <= S_WAIT;
          end
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Testbench for gate_sweep_ctrl. Three instances (N_IN = 1, 2, 3, SETTLE = 2)
// each drive a behavioural GUT. That GUT can be correct, stuck-at-0, inverted,
// or faulty only at vector 2. A linear directed sequence checks the results.
module tb_gate_sweep_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- instance 1: N_IN=1 ----------------
  logic       start1 = 1'b0;
  logic [2:0] op_sel1 = 3'd0;
  logic       dut_z1;
  logic [0:0] vec1;
  logic       busy1, done1, pass1, fv1;
  logic [1:0] err1;
  logic [0:0] ffv1;
  int         mode1 = 0;
  logic [2:0] gut_op1 = 3'd0;

  gate_sweep_ctrl #(.N_IN(1), .SETTLE(2)) u1 (
    .clk(clk), .rst(rst), .start(start1), .op_sel(op_sel1), .dut_z(dut_z1),
    .vec_out(vec1), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err1), .fail_valid(fv1), .first_fail_vec(ffv1)
  );

  // ---------------- instance 2: N_IN=2 ----------------
  logic       start2 = 1'b0;
  logic [2:0] op_sel2 = 3'd0;
  logic       dut_z2;
  logic [1:0] vec2;
  logic       busy2, done2, pass2, fv2;
  logic [2:0] err2;
  logic [1:0] ffv2;
  int         mode2 = 0;
  logic [2:0] gut_op2 = 3'd0;

  gate_sweep_ctrl #(.N_IN(2), .SETTLE(2)) u2 (
    .clk(clk), .rst(rst), .start(start2), .op_sel(op_sel2), .dut_z(dut_z2),
    .vec_out(vec2), .busy(busy2), .done(done2), .pass(pass2),
    .err_cnt(err2), .fail_valid(fv2), .first_fail_vec(ffv2)
  );

  // ---------------- instance 3: N_IN=3 ----------------
  logic       start3 = 1'b0;
  logic [2:0] op_sel3 = 3'd0;
  logic       dut_z3;
  logic [2:0] vec3;
  logic       busy3, done3, pass3, fv3;
  logic [3:0] err3;
  logic [2:0] ffv3;
  int         mode3 = 0;
  logic [2:0] gut_op3 = 3'd0;

  gate_sweep_ctrl #(.N_IN(3), .SETTLE(2)) u3 (
    .clk(clk), .rst(rst), .start(start3), .op_sel(op_sel3), .dut_z(dut_z3),
    .vec_out(vec3), .busy(busy3), .done(done3), .pass(pass3),
    .err_cnt(err3), .fail_valid(fv3), .first_fail_vec(ffv3)
  );

  // Reference gate, evaluated bit by bit over the n active inputs.
  function automatic logic ref_gate(input logic [2:0] op, input logic [7:0] v, input int n);
    logic a, o, x;
    a = 1'b1; o = 1'b0; x = 1'b0;
    for (int i = 0; i < n; i++) begin
      a = a & v[i];
      o = o | v[i];
      x = x ^ v[i];
    end
    case (op)
      3'd0:    return !v[0];
      3'd1:    return a;
      3'd2:    return o;
      3'd3:    return !a;
      3'd4:    return !o;
      3'd5:    return x;
      3'd6:    return !x;
      default: return v[0];
    endcase
  endfunction

  // GUT behaviour: 0 good, 1 stuck-at-0, 2 inverted, 3 wrong only at vector 2.
  function automatic logic gut(input int mode, input logic [2:0] op, input logic [7:0] v, input int n);
    logic g;
    g = ref_gate(op, v, n);
    case (mode)
      1:       return 1'b0;
      2:       return !g;
      3:       return g ^ (v == 8'd2);
      default: return g;
    endcase
  endfunction

  assign dut_z1 = gut(mode1, gut_op1, {7'b0, vec1}, 1);
  assign dut_z2 = gut(mode2, gut_op2, {6'b0, vec2}, 2);
  assign dut_z3 = gut(mode3, gut_op3, {5'b0, vec3}, 3);

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic done_of(input int which);
    case (which)
      1:       return done1;
      2:       return done2;
      default: return done3;
    endcase
  endfunction

  // Pulse start on one instance, then count edges until its done pulse
  // (cyc = number of edges after the start edge). Bounded by a budget.
  task automatic sweep(input int which, input logic [2:0] op, input int mode, output int cyc);
    cyc = 0;
    case (which)
      1: begin start1 = 1'b1; op_sel1 = op; gut_op1 = op; mode1 = mode; end
      2: begin start2 = 1'b1; op_sel2 = op; gut_op2 = op; mode2 = mode; end
      default: begin start3 = 1'b1; op_sel3 = op; gut_op3 = op; mode3 = mode; end
    endcase
    tick();
    start1 = 1'b0; start2 = 1'b0; start3 = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (done_of(which)) begin
        cyc = k;
        break;
      end
    end
    if (cyc == 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  int cyc;

  initial begin
    // ---------------- reset ----------------
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_vec2", vec2, 0);
    check("rst_busy2", busy2, 0);
    check("rst_done2", done2, 0);
    check("rst_pass2", pass2, 0);
    check("rst_err2", err2, 0);
    check("rst_fv2", fv2, 0);
    check("rst_ffv2", ffv2, 0);
    check("rst_busy1", busy1, 0);
    check("rst_busy3", busy3, 0);

    // ---------------- good NOT, N_IN=1: exact timing ----------------
    start1 = 1'b1; op_sel1 = 3'd0; gut_op1 = 3'd0; mode1 = 0;
    tick();                                   // edge 0
    start1 = 1'b0;
    check("t1_vec_e0", vec1, 0);
    check("t1_busy_e0", busy1, 1);
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("t1_done_e%0d", k), done1, (k == 6));
      if (k == 2) check("t1_vec_e2", vec1, 0);
      if (k == 3) check("t1_vec_e3", vec1, 1);
    end
    check("t1_pass", pass1, 1);
    check("t1_err", err1, 0);
    check("t1_fv", fv1, 0);
    check("t1_busy_done", busy1, 1);
    tick();
    check("t1_done_after", done1, 0);
    check("t1_busy_after", busy1, 0);
    check("t1_pass_held", pass1, 1);

    // ---------------- NAND vs stuck-at-0, N_IN=2 ----------------
    sweep(2, 3'd3, 1, cyc);
    check("t2_cyc", cyc, 12);
    check("t2_err", err2, 3);
    check("t2_ffv", ffv2, 2'b00);
    check("t2_fv", fv2, 1);
    check("t2_pass", pass2, 0);
    tick();

    // ---------------- XOR vs XNOR model, N_IN=3 ----------------
    sweep(3, 3'd5, 2, cyc);
    check("t3_cyc", cyc, 24);
    check("t3_err", err3, 8);
    check("t3_ffv", ffv3, 3'b000);
    check("t3_pass", pass3, 0);
    tick();

    // ---------------- AND failing only at 2'b10 ----------------
    sweep(2, 3'd1, 3, cyc);
    check("t4_err", err2, 1);
    check("t4_ffv", ffv2, 2'b10);
    check("t4_fv", fv2, 1);
    check("t4_pass", pass2, 0);
    tick();

    // ---------------- start re-pulsed mid-sweep is ignored ----------------
    start2 = 1'b1; op_sel2 = 3'd1; gut_op2 = 3'd1; mode2 = 0;
    tick();                                   // edge 0
    start2 = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 3) begin start2 = 1'b1; op_sel2 = 3'd4; end  // sampled at edge 4
      if (k == 4) start2 = 1'b0;
      check($sformatf("t5_done_e%0d", k), done2, (k == 12));
      if (k == 12) begin
        check("t5_pass", pass2, 1);
        check("t5_err", err2, 0);
      end
    end
    check("t5_busy_end", busy2, 0);

    // ---------------- reset mid-sweep, then reset+start together ----------------
    start2 = 1'b1; op_sel2 = 3'd4; gut_op2 = 3'd4; mode2 = 1;
    tick();                                   // edge 0
    start2 = 1'b0;
    tick(); tick(); tick(); tick();           // edges 1..4
    check("t6_err_pre", err2, 1);
    check("t6_fv_pre", fv2, 1);
    rst = 1'b1;
    tick();                                   // edge 5
    check("t6_rst_busy", busy2, 0);
    check("t6_rst_done", done2, 0);
    check("t6_rst_err", err2, 0);
    check("t6_rst_fv", fv2, 0);
    check("t6_rst_pass", pass2, 0);
    check("t6_rst_vec", vec2, 0);
    start2 = 1'b1; op_sel2 = 3'd2; gut_op2 = 3'd2; mode2 = 0;
    tick();
    check("t6_rst_wins", busy2, 0);
    rst = 1'b0;
    tick();
    check("t6_busy_start", busy2, 1);
    check("t6_vec_start", vec2, 0);
    start2 = 1'b0;
    cyc = 0;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (done2) begin
        cyc = k;
        break;
      end
    end
    check("t6_cyc", cyc, 12);
    check("t6_pass", pass2, 1);
    check("t6_err", err2, 0);
    tick();
    check("t6_idle", busy2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_sweep_ctrl.md
# gate_sweep_ctrl

Sequencer that exhaustively exercises one combinational gate under test (GUT), such as the team's NOT/AND/OR cells. On `start` it drives every input vector in ascending binary order and waits a programmable settle time after each. It then compares the GUT output with the expected truth-table value for the selected gate, and reports pass/fail, the mismatch count and the first failing vector. It sits between the bench/top-level control and the gate cells, and owns the gate inputs for the whole sweep.

## Interface
Parameters:
- `N_IN`, default 2: number of GUT inputs (1–8). Gate types that take one input use bit 0 only.
- `SETTLE`, default 2: cycles each vector is held before the output is sampled; must be ≥1.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a sweep. Sampled only in IDLE.
- `op_sel`  in  3  gate type: 0 NOT, 1 AND, 2 OR, 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 BUF. Latched on accepted `start`.
- `dut_z`  in  1  GUT output.
- `vec_out`  out  N_IN  registered vector driven to the GUT inputs.
- `busy`  out  1  high whenever the state is not IDLE.
- `done`  out  1  one-cycle pulse in the DONE state.
- `pass`  out  1  set in DONE when `err_cnt`==0; held until the next accepted `start` or `rst`.
- `err_cnt`  out  N_IN+1  number of mismatching vectors in the current or last sweep.
- `fail_valid`  out  1  at least one mismatch has been captured.
- `first_fail_vec`  out  N_IN  vector of the first mismatch; valid only when `fail_valid` is high.

## Operation
- Reset values: state IDLE; `vec_out`=0, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, `fail_valid`=0, `first_fail_vec`=0.
- Internal state: latched op `op_q`, settle counter `cnt` (width clog2(SETTLE)+1).
- Expected value, computed from `vec_out` and `op_q`:
  - NOT = ~v[0]; BUF = v[0].
  - AND = &v; NAND = ~&v.
  - OR = |v; NOR = ~|v.
  - XOR = ^v; XNOR = ~^v.

FSM states and transitions:
- IDLE
  - On `start`=1: `op_q`<=`op_sel`, `vec_out`<=0, `err_cnt`<=0, `fail_valid`<=0, `first_fail_vec`<=0, `pass`<=0, `cnt`<=SETTLE-1, go to WAIT.
  - Otherwise hold all outputs.
- WAIT
  - If `cnt`!=0: `cnt`<=`cnt`-1, stay in WAIT.
  - If `cnt`==0: go to CHECK.
  - WAIT lasts exactly SETTLE cycles.
- CHECK: sample `dut_z` and compare it with the expected value.
  - On mismatch: `err_cnt`<=`err_cnt`+1.
  - If this is a mismatch and `fail_valid`==0: `first_fail_vec`<=`vec_out`, `fail_valid`<=1.
  - If `vec_out`==all-ones: go to DONE with `vec_out` held.
  - Otherwise: `vec_out`<=`vec_out`+1, `cnt`<=SETTLE-1, go to WAIT.
- DONE
  - `done`=1 for this cycle only.
  - `pass`<=(final `err_cnt`==0). This uses the post-CHECK value, which includes the last vector.
  - Go to IDLE.

Boundary conditions:
- `start` in any state other than IDLE is ignored, with no effect on the sweep.
- `start` held high continuously: a new sweep begins on the first IDLE cycle after DONE.
- `err_cnt` cannot overflow: its maximum is 2^N_IN, which fits in N_IN+1 bits.
- `vec_out` never wraps past all-ones during a sweep.
- `rst` mid-sweep: next cycle is IDLE with all outputs at their reset values. No `done` pulse is produced.
- `rst` and `start` asserted together: reset wins.

## Timing
- Accepted `start` at edge 0: `vec_out`=0 and `busy`=1 are visible from edge 0.
- Each vector occupies SETTLE+1 cycles (SETTLE in WAIT, 1 in CHECK).
- `dut_z` is sampled at the end of the CHECK cycle. The GUT path must settle within SETTLE+1 clock periods.
- `done` is high in the cycle after edge 2^N_IN·(SETTLE+1).
- `busy` falls, and IDLE is re-entered, one edge later.
- `pass`, `err_cnt` and `first_fail_vec` are final and stable while `done`=1, and are held through IDLE.

## Test plan
- Good NOT model, N_IN=1, SETTLE=2, op_sel=0, `start` pulsed at edge 0: `vec_out` sequence is 0,1; `done` high in the cycle after edge 6; `pass`=1; `err_cnt`=0; `fail_valid`=0.
- N_IN=2, op_sel=3 (NAND), GUT stuck-at-0: `err_cnt`=3, `first_fail_vec`=2'b00, `fail_valid`=1, `pass`=0.
- N_IN=3, op_sel=5 (XOR), GUT modelled as XNOR: `err_cnt`=8, `first_fail_vec`=3'b000, `pass`=0.
- N_IN=2, op_sel=1 (AND), GUT fails only at vector 2'b10: `err_cnt`=1, `first_fail_vec`=2'b10.
- N_IN=2, SETTLE=2, `start` re-pulsed at cycle 4 of a sweep: ignored; `done` occurs once, in the cycle after edge 12.
- `rst` asserted at cycle 5 of a sweep: next cycle is IDLE with all outputs zero and no `done` pulse; a fresh `start` then completes normally.
